// File: rtl/mem_sched_pkg.sv
// Shared definitions for the round-robin memory scheduler: FSM encoding,
// sticky error bit positions and the per-request control width.
package mem_sched_pkg;

  localparam int unsigned NCORES_MAX = 8;
  localparam int unsigned CTRL_W     = 3;

  localparam int unsigned ERR_LEWE     = 0;
  localparam int unsigned ERR_BUSYIDLE = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: returns the first set bit of
// pending when scanning ptr+1, ptr+2, ... modulo NCORES.
module rr_pick
  import mem_sched_pkg::*;
#(
  parameter int unsigned NCORES = 2,
  parameter int unsigned GW     = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] pending,
  input  logic [GW-1:0]     ptr,
  output logic [GW-1:0]     idx,
  output logic              any
);

  // Scan from the slot after the last-served core; the served core itself comes last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= int'(NCORES); k++) begin
      if (!any && pending[(int'(ptr) + k) % int'(NCORES)]) begin
        idx = GW'((int'(ptr) + k) % int'(NCORES));
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler sharing one memory port between NCORES cores.
// Each core's request is captured into a slot, issued one at a time with a
// busy-rise / busy-fall handshake, and the core is held busy until done.
// Optional: define MEM_SCHED_TIMEOUT_EN to abort an issue whose m_busy never
// rises within TIMEOUT cycles (err[2], read data all-ones).
module mem_rr_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned NCORES  = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                       CLK,
  input  logic                       RST_X,
  input  logic                       en,
  input  logic [NCORES-1:0]          c_le,
  input  logic [NCORES-1:0]          c_we,
  input  logic [NCORES*AW-1:0]       c_addr,
  input  logic [NCORES*DW-1:0]       c_wdata,
  input  logic [NCORES*CTRL_W-1:0]   c_ctrl,
  output logic [NCORES-1:0]          c_busy,
  output logic [NCORES*DW-1:0]       c_rdata,
  output logic                       m_le,
  output logic                       m_we,
  output logic [AW-1:0]              m_addr,
  output logic [DW-1:0]              m_wdata,
  output logic [CTRL_W-1:0]          m_ctrl,
  input  logic                       m_busy,
  input  logic [DW-1:0]              m_rdata,
  output logic [$clog2(NCORES)-1:0]  grant,
  output logic                       grant_vld,
  output logic [2:0]                 err
);

  localparam int unsigned GW = $clog2(NCORES);

  state_e              state_q;
  logic [GW-1:0]       ptr_q;
  logic [GW-1:0]       grant_q;
  logic                grant_vld_q;
  // A pending slot is exactly a busy core: set on capture, cleared on completion.
  logic [NCORES-1:0]   pending_q;
  logic [AW-1:0]       slot_addr_q  [NCORES];
  logic [DW-1:0]       slot_wdata_q [NCORES];
  logic [CTRL_W-1:0]   slot_ctrl_q  [NCORES];
  logic [NCORES-1:0]   slot_we_q;
  logic [NCORES*DW-1:0] rdata_q;
  logic                m_le_q;
  logic                m_we_q;
  logic [AW-1:0]       m_addr_q;
  logic [DW-1:0]       m_wdata_q;
  logic [CTRL_W-1:0]   m_ctrl_q;
  logic [2:0]          err_q;

  logic [GW-1:0]       pick_idx;
  logic                pick_any;

`ifdef MEM_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_q;
`endif

  rr_pick #(
    .NCORES (NCORES),
    .GW     (GW)
  ) u_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // Request capture, issue FSM and registered memory-side outputs.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q     <= ST_IDLE;
      ptr_q       <= GW'(NCORES - 1);
      grant_q     <= '0;
      grant_vld_q <= 1'b0;
      pending_q   <= '0;
      slot_we_q   <= '0;
      rdata_q     <= '0;
      m_le_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_ctrl_q    <= '0;
      err_q       <= '0;
      for (int i = 0; i < int'(NCORES); i++) begin
        slot_addr_q[i]  <= '0;
        slot_wdata_q[i] <= '0;
        slot_ctrl_q[i]  <= '0;
      end
`ifdef MEM_SCHED_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      // Capture runs alongside issue; a busy core cannot post a second request.
      if (en) begin
        for (int i = 0; i < int'(NCORES); i++) begin
          if (!pending_q[i] && (c_le[i] || c_we[i])) begin
            slot_addr_q[i]  <= c_addr[i*AW +: AW];
            slot_wdata_q[i] <= c_wdata[i*DW +: DW];
            slot_ctrl_q[i]  <= c_ctrl[i*CTRL_W +: CTRL_W];
            slot_we_q[i]    <= c_we[i];
            pending_q[i]    <= 1'b1;
            if (c_le[i] && c_we[i]) err_q[ERR_LEWE] <= 1'b1;
          end
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (m_busy) err_q[ERR_BUSYIDLE] <= 1'b1;
          if (en && pick_any) begin
            grant_q     <= pick_idx;
            grant_vld_q <= 1'b1;
            m_le_q      <= ~slot_we_q[pick_idx];
            m_we_q      <= slot_we_q[pick_idx];
            m_addr_q    <= slot_addr_q[pick_idx];
            m_wdata_q   <= slot_wdata_q[pick_idx];
            m_ctrl_q    <= slot_ctrl_q[pick_idx];
            state_q     <= ST_ISSUE;
`ifdef MEM_SCHED_TIMEOUT_EN
            tmo_q       <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (m_busy) begin
            m_le_q  <= 1'b0;
            m_we_q  <= 1'b0;
            state_q <= ST_WAIT;
`ifdef MEM_SCHED_TIMEOUT_EN
          end else if (tmo_q == CW'(TIMEOUT - 1)) begin
            // Memory never answered: finish the request with a poisoned result.
            m_le_q                        <= 1'b0;
            m_we_q                        <= 1'b0;
            err_q[ERR_TIMEOUT]            <= 1'b1;
            rdata_q[int'(grant_q)*DW +: DW] <= '1;
            pending_q[grant_q]            <= 1'b0;
            ptr_q                         <= grant_q;
            grant_vld_q                   <= 1'b0;
            state_q                       <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
`endif
          end
        end
        ST_WAIT: begin
          if (!m_busy) begin
            if (!slot_we_q[grant_q]) rdata_q[int'(grant_q)*DW +: DW] <= m_rdata;
            pending_q[grant_q] <= 1'b0;
            ptr_q              <= grant_q;
            grant_vld_q        <= 1'b0;
            state_q            <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign c_busy    = pending_q;
  assign c_rdata   = rdata_q;
  assign m_le      = m_le_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_ctrl    = m_ctrl_q;
  assign grant     = grant_q;
  assign grant_vld = grant_vld_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Bench for mem_rr_scheduler: table of single transactions plus directed
// sequences for contention, protocol errors, reset mid-flight and timeout.
module tb_mem_rr_scheduler;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            CLK = 1'b0;
  logic            RST_X = 1'b0;
  logic            en = 1'b0;
  logic [N-1:0]    c_le = '0;
  logic [N-1:0]    c_we = '0;
  logic [N*AW-1:0] c_addr = '0;
  logic [N*DW-1:0] c_wdata = '0;
  logic [N*3-1:0]  c_ctrl = '0;
  logic [N-1:0]    c_busy;
  logic [N*DW-1:0] c_rdata;
  logic            m_le, m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [2:0]      m_ctrl;
  logic            m_busy;
  logic [DW-1:0]   m_rdata;
  logic [0:0]      grant;
  logic            grant_vld;
  logic [2:0]      err;

  int errors = 0;
  int checks = 0;

  // Memory model state (written only by the model process)
  logic        mb_q = 1'b0;
  logic [31:0] mrd_q = '0;
  int          wait_cnt = 0, hold_cnt = 0, strobe_run = 0, last_strobe_len = 0, overlap = 0;
  int          log_grant[$];
  bit          log_we[$];
  // Model controls (written only by the test process)
  int          mem_lat = 1, mem_hold = 4;
  bit          mem_on = 1'b1, mem_kill = 1'b0, force_busy = 1'b0;

  assign m_busy  = (mb_q & ~mem_kill) | force_busy;
  assign m_rdata = mrd_q;

  always #5 CLK = ~CLK;

  mem_rr_scheduler #(
    .NCORES  (N),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (8)
  ) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .en        (en),
    .c_le      (c_le),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_ctrl    (c_ctrl),
    .c_busy    (c_busy),
    .c_rdata   (c_rdata),
    .m_le      (m_le),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ctrl    (m_ctrl),
    .m_busy    (m_busy),
    .m_rdata   (m_rdata),
    .grant     (grant),
    .grant_vld (grant_vld),
    .err       (err)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h8000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
  endfunction

  // Memory: raises busy mem_lat cycles after a strobe, holds it mem_hold cycles.
  always @(negedge CLK) begin
    if (m_le && m_we) overlap++;
    if (m_le || m_we) strobe_run++;
    else if (strobe_run != 0) begin
      last_strobe_len = strobe_run;
      strobe_run = 0;
    end
    if (mem_kill) begin
      mb_q = 1'b0; wait_cnt = 0; hold_cnt = 0;
    end else if (mb_q) begin
      hold_cnt--;
      if (hold_cnt == 0) begin
        mb_q  = 1'b0;
        mrd_q = mem_val(m_addr);
      end
    end else if (mem_on && (m_le || m_we)) begin
      if (wait_cnt >= mem_lat) begin
        mb_q = 1'b1; hold_cnt = mem_hold; wait_cnt = 0;
        log_grant.push_back(int'(grant));
        log_we.push_back(m_we);
      end else wait_cnt++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_X = 1'b0; c_le = '0; c_we = '0;
    @(negedge CLK);
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  task automatic drive(input int core, input bit le, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] ctrl);
    c_le[core] = le;
    c_we[core] = we;
    c_addr[core*AW +: AW]  = addr;
    c_wdata[core*DW +: DW] = wdata;
    c_ctrl[core*3 +: 3]    = ctrl;
  endtask

  task automatic wait_idle(input logic [N-1:0] mask, input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((c_busy & mask) == '0) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    chk(name, 64'(done), 64'(1));
  endtask

  typedef struct {
    int          core;
    bit          le;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vec [5];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int rem [N];

    vec[0] = '{0, 1'b1, 1'b0, 32'h8000_1000, 32'h0000_0000, 3'd2, 32'hDEAD_BEEF};
    vec[1] = '{1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 3'd2, 32'h0000_0000};
    vec[2] = '{1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, 3'd2, 32'h5A5A_5A1A};
    vec[3] = '{0, 1'b0, 1'b1, 32'h8000_1000, 32'hAABB_CCDD, 3'd1, 32'hDEAD_BEEF};
    vec[4] = '{0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 3'd5, 32'h5A5A_5B5A};

    en = 1'b1;
    do_reset();
    @(negedge CLK);
    chk("rst_busy", 64'(c_busy), 64'(0));
    chk("rst_gvld", 64'(grant_vld), 64'(0));
    chk("rst_strobe", 64'({m_le, m_we}), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_rdata", 64'(c_rdata), 64'(0));
    chk("rst_addr", 64'(m_addr), 64'(0));

    // Table: one transaction at a time, checking latency, strobe width and results.
    for (int v = 0; v < 5; v++) begin
      base = log_grant.size();
      drive(vec[v].core, vec[v].le, vec[v].we, vec[v].addr, vec[v].wdata, vec[v].ctrl);
      @(negedge CLK);
      chk($sformatf("v%0d_busy_set", v), 64'(c_busy[vec[v].core]), 64'(1));
      chk($sformatf("v%0d_idle_cycle", v), 64'(grant_vld), 64'(0));
      c_le = '0; c_we = '0;
      @(negedge CLK);
      chk($sformatf("v%0d_issue", v), 64'({grant_vld, grant, m_le, m_we}),
          64'({1'b1, 1'(vec[v].core), ~vec[v].we, vec[v].we}));
      wait_idle(N'(1) << vec[v].core, $sformatf("v%0d_done", v));
      chk($sformatf("v%0d_rdata", v), 64'(c_rdata[vec[v].core*DW +: DW]), 64'(vec[v].exp_rdata));
      chk($sformatf("v%0d_maddr", v), 64'(m_addr), 64'(vec[v].addr));
      chk($sformatf("v%0d_mwdata", v), 64'(m_wdata), 64'(vec[v].wdata));
      chk($sformatf("v%0d_mctrl", v), 64'(m_ctrl), 64'(vec[v].ctrl));
      chk($sformatf("v%0d_strobe_len", v), 64'(last_strobe_len), 64'(2));
      chk($sformatf("v%0d_nlog", v), 64'(log_grant.size()), 64'(base + 1));
      if (log_grant.size() > base) begin
        chk($sformatf("v%0d_op", v), 64'(log_we[base]), 64'(vec[v].we));
        chk($sformatf("v%0d_grant", v), 64'(log_grant[base]), 64'(vec[v].core));
      end
    end

    // Contention: both cores post four loads each, re-requesting as soon as free.
    do_reset();
    base = log_grant.size();
    rem[0] = 4; rem[1] = 4;
    begin
      bit fin = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        @(negedge CLK);
        c_le = '0;
        if (rem[0] == 0 && rem[1] == 0 && c_busy == '0) begin
          fin = 1'b1;
          break;
        end
        for (int i = 0; i < N; i++) begin
          if (!c_busy[i] && rem[i] > 0) begin
            drive(i, 1'b1, 1'b0, 32'(32'h1000 * (i + 1) + 4 * (4 - rem[i])), 32'h0, 3'd2);
            rem[i]--;
          end
        end
      end
      chk("cont_finished", 64'(fin), 64'(1));
    end
    chk("cont_nlog", 64'(log_grant.size()), 64'(base + 8));
    for (int k = 0; k < 8; k++) begin
      if (base + k < log_grant.size())
        chk($sformatf("cont_grant%0d", k), 64'(log_grant[base + k]), 64'(k % 2));
    end
    chk("cont_rdata0", 64'(c_rdata[0 +: DW]), 64'(32'h5A5A_4A56));
    chk("cont_rdata1", 64'(c_rdata[DW +: DW]), 64'(32'h5A5A_7A56));
    chk("no_le_we_overlap", 64'(overlap), 64'(0));

    // le and we together: served as a store and flagged.
    do_reset();
    base = log_grant.size();
    @(negedge CLK);
    drive(1, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0077, 3'd2);
    @(negedge CLK);
    c_le = '0; c_we = '0;
    wait_idle(2'b10, "lewe_done");
    chk("lewe_err", 64'(err), 64'(3'b001));
    chk("lewe_rdata", 64'(c_rdata[DW +: DW]), 64'(0));
    chk("lewe_wdata", 64'(m_wdata), 64'(32'h0000_0077));
    if (log_we.size() > base) chk("lewe_is_store", 64'(log_we[base]), 64'(1));

    // m_busy high while idle: sticky err[1].
    @(negedge CLK);
    force_busy = 1'b1;
    @(negedge CLK);
    force_busy = 1'b0;
    chk("busyidle_err", 64'(err), 64'(3'b011));
    repeat (5) @(negedge CLK);
    chk("busyidle_sticky", 64'(err), 64'(3'b011));

    // en low blocks capture.
    en = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 3'd2);
    @(negedge CLK);
    chk("en_low_nocapture", 64'(c_busy), 64'(0));
    c_le = '0;
    en = 1'b1;
    do_reset();
    @(negedge CLK);
    chk("err_cleared", 64'(err), 64'(0));

    // Reset while a request sits in WAIT.
    mem_hold = 20;
    drive(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 3'd2);
    @(negedge CLK);
    c_le = '0;
    repeat (4) @(negedge CLK);
    chk("midwait_inflight", 64'({grant_vld, m_le}), 64'({1'b1, 1'b0}));
    RST_X = 1'b0;
    mem_kill = 1'b1;
    @(negedge CLK);
    RST_X = 1'b1;
    chk("midwait_busy", 64'(c_busy), 64'(0));
    chk("midwait_gvld", 64'(grant_vld), 64'(0));
    chk("midwait_strobe", 64'({m_le, m_we}), 64'(0));
    @(negedge CLK);
    mem_kill = 1'b0;
    mem_hold = 4;
    base = log_grant.size();
    drive(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 3'd2);
    drive(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 3'd2);
    @(negedge CLK);
    c_le = '0;
    wait_idle(2'b11, "midwait_fresh_done");
    chk("midwait_nlog", 64'(log_grant.size()), 64'(base + 2));
    if (log_grant.size() > base + 1) begin
      chk("midwait_first", 64'(log_grant[base]), 64'(0));
      chk("midwait_second", 64'(log_grant[base + 1]), 64'(1));
    end
    chk("midwait_err", 64'(err), 64'(0));

`ifdef MEM_SCHED_TIMEOUT_EN
    // Memory never answers: strobe held TIMEOUT cycles, then poisoned completion.
    do_reset();
    mem_on = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 3'd2);
    @(negedge CLK);
    c_le = '0;
    wait_idle(2'b01, "tmo_done");
    @(negedge CLK);
    chk("tmo_strobe_len", 64'(last_strobe_len), 64'(8));
    chk("tmo_err", 64'(err), 64'(3'b100));
    chk("tmo_rdata", 64'(c_rdata[0 +: DW]), 64'(32'hFFFF_FFFF));
    chk("tmo_busy", 64'(c_busy), 64'(0));
    mem_on = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_rr_scheduler.md
Name: mem_rr_scheduler

Overview:
- Round-robin scheduler that shares the single DRAM/data memory port between NCORES cores.
- Captures each core's load/store request and holds that core busy until its request completes.
- Issues one request at a time to the memory subsystem, using a busy-rise / busy-fall completion handshake.
- Sits between the per-core bus ports and the DRAM controller / MMIO data path; it generalises two-core fixed-priority granting to N-way fair sharing.

Parameters:
- NCORES, 2, number of requesting cores (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 1023, max cycles to wait for m_busy to rise (used only with the optional feature).

Ports:
- CLK  in  1  clock.
- RST_X  in  1  synchronous active-low reset.
- en  in  1  scheduler enable (init done); while low, no capture and no issue.
- c_le  in  NCORES  per-core load request.
- c_we  in  NCORES  per-core store request.
- c_addr  in  NCORES*AW  per-core address (core i at bits [i*AW +: AW]).
- c_wdata  in  NCORES*DW  per-core write data.
- c_ctrl  in  NCORES*3  per-core size/sign control.
- c_busy  out  NCORES  per-core request outstanding.
- c_rdata  out  NCORES*DW  per-core read data, held until the next completion for that core.
- m_le  out  1  load strobe to memory.
- m_we  out  1  store strobe to memory.
- m_addr  out  AW  address to memory.
- m_wdata  out  DW  write data to memory.
- m_ctrl  out  3  control to memory.
- m_busy  in  1  memory busy.
- m_rdata  in  DW  memory read data, valid when m_busy falls.
- grant  out  $clog2(NCORES)  index of the core owning the port.
- grant_vld  out  1  a request is in flight.
- err  out  3  sticky flags: [0] le&we together, [1] m_busy high in IDLE, [2] timeout.

Behaviour:
- Reset values (RST_X low at posedge CLK): all outputs 0; rdata regs 0; pending 0; rr pointer = NCORES-1, so core 0 wins first; state IDLE. Reset mid-operation aborts the in-flight request silently.
- Capture: at a posedge with en=1, c_busy[i]=0 and (c_le[i]|c_we[i]) high, latch addr/wdata/ctrl/op into slot i and set pending[i]=1 and c_busy[i]=1 on that edge. Requests from a busy core are ignored. Capture runs in every state, concurrently with issue.
- le&we both high: treated as a store; err[0] set.
- State IDLE: if any pending, pick the first pending index scanning ptr+1, ptr+2, ... mod NCORES. Set grant, grant_vld=1, go ISSUE.
  - A request captured in cycle t can be picked at t+1 at the earliest.
  - m_busy=1 in IDLE sets err[1]; the scheduler still proceeds.
- State ISSUE: drive m_le/m_we and the slot fields from slot[grant]. When m_busy=1 is sampled, drop m_le/m_we on that edge and go WAIT. The strobe is therefore high for at least 1 cycle and until the busy rise.
- State WAIT:
  - When m_busy=0 is sampled: latch c_rdata[grant]<=m_rdata (loads only; stores leave c_rdata unchanged); clear c_busy[grant] and pending[grant]; ptr<=grant; grant_vld<=0; go IDLE.
  - The core may re-request in the cycle after c_busy falls.
- m_addr/m_wdata/m_ctrl hold the slot[grant] values in ISSUE and WAIT, and keep their last value in IDLE. m_le/m_we are 0 outside ISSUE.
- Throughput: 1 IDLE cycle + ISSUE + WAIT per request. Back-to-back requests from different cores alternate strictly under contention, so no core waits more than NCORES-1 services.
- en low: the in-flight request completes; no new capture or issue.

Optional Feature:
- Macro MEM_SCHED_TIMEOUT_EN.
- Defined: a counter runs in ISSUE. If m_busy has not risen after TIMEOUT cycles, drop the strobes, set err[2], and complete the request with c_rdata[grant]=all-ones. Rotation is normal.
- Undefined: ISSUE waits indefinitely; err[2] is tied 0 and no counter is built.

Decomposition:
- Shared package mem_sched_pkg:
  - state encoding ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2;
  - error bit indices ERR_LEWE/ERR_BUSYIDLE/ERR_TIMEOUT;
  - NCORES_MAX=8;
  - CTRL width 3.
- One sub-module: rr_pick, a combinational rotate-priority picker taking the pending vector and ptr, returning index + any.

Test Plan:
- Single load: core0 c_le=1 addr 0x80001000; memory raises busy 1 cycle after m_le, holds busy 4 cycles, m_rdata=0xDEADBEEF -> m_le high exactly until busy seen; c_busy[0] falls with c_rdata[0]=0xDEADBEEF; grant=0.
- Contention: cores 0 and 1 request in the same cycle, 4 requests each, back-to-back -> grants 0,1,0,1,...; neither core served twice in a row.
- Store then load, same core: c_we wdata 0x12345678 then c_le -> c_rdata unchanged after the store; m_we never coincides with m_le.
- Protocol errors: le&we together -> handled as store, err=3'b001; force m_busy=1 in IDLE -> err[1] set and sticky until reset.
- Reset mid-WAIT: assert RST_X=0 one cycle -> all c_busy=0, grant_vld=0, m_le=m_we=0 next edge; a fresh request afterwards is granted to core 0 first.
- MEM_SCHED_TIMEOUT_EN with TIMEOUT=8 and m_busy held 0 -> strobe dropped after 8 cycles; err[2]=1; c_rdata=0xFFFFFFFF; c_busy cleared.
